src_alu32: RTL and testbench
============================

# src_alu32

Mini-SRC 32-bit ALU with its result register pair Z (Zhigh/Zlow). Operand A comes from the Y register and operand B from the shared bus. The opcode comes from the control unit's decoded IR field. The 64-bit result {HI, LO} is captured into Zhigh/Zlow, and the control unit then drives those onto the bus with Zhighout/Zlowout.

## Interface
- No parameters.
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset; clears Zhigh and Zlow.
- A  in  32  operand A (Y register output).
- B  in  32  operand B (BusMuxOut).
- opcode  in  5  operation select.
- IncPC  in  1  PC-increment override; takes priority over opcode.
- branch_flag  in  1  CON flip-flop output, used by op brx.
- Zhighin  in  1  load enable for Zhigh.
- Zlowin  in  1  load enable for Zlow.
- C_out_HI  out  32  Zhigh register contents.
- C_out_LO  out  32  Zlow register contents.

## Operation
Combinational result {HI, LO}. HI = 0 unless stated otherwise.
- IncPC=1: LO = B + 1, regardless of opcode.
- 00000 ld, 00001 ldi, 00010 st, 01100 addi, 00011 add: LO = A + B. Modulo 2^32; carry is discarded.
- 00100 sub: LO = A − B.
- 00101 and / 01101 andi: LO = A & B.
- 00110 or / 01110 ori: LO = A | B.
- 00111 shr: logical right shift of A by B[4:0].
- 01000 shra: arithmetic right shift of A by B[4:0].
- 01001 shl: left shift of A by B[4:0].
- 01010 ror / 01011 rol: rotate A right/left by B[4:0]. Amount 0 returns A unchanged.
- 01111 mul: signed 64-bit product A×B. HI = bits 63:32, LO = bits 31:0.
- 10000 div (signed):
  - LO = quotient truncated toward zero; HI = remainder, which takes the sign of A.
  - B = 0: LO = 32'hFFFFFFFF, HI = A.
  - A = 32'h80000000 and B = −1: LO = 32'h80000000, HI = 0.
- 10001 neg: LO = −B (two's complement).
- 10010 not: LO = ~B.
- 10011 brx: LO = branch_flag ? A + B : A. A holds the PC; B holds the sign-extended C field.
- Any other opcode (jr, jal, in, out, mfhi, mflo, nop, halt, reserved): LO = B pass-through, HI = 0.

## Timing
- Result logic is purely combinational, with no internal state other than Z.
- On a rising clock edge:
  - Zhighin=1 loads Zhigh ← HI.
  - Zlowin=1 loads Zlow ← LO.
  - The two enables are independent; both may be asserted in the same cycle.
  - With an enable at 0, the corresponding register holds its value.
- Latency: operands valid before edge N appear on C_out_HI/C_out_LO after edge N (1 cycle).
- clear low sets C_out_HI = C_out_LO = 0 immediately, independent of clock.
  - The registers stay 0 while clear is low; load enables are ignored.
  - Loading resumes on the first rising edge after clear deasserts.
- mul and div complete within the single cycle; no handshake and no busy signal.

## Configuration
- Macro ALU_DIV_EN.
- Defined: divider is compiled in and behaves as specified for opcode 10000.
- Undefined: no divider logic is built; opcode 10000 yields HI = 0, LO = 0. All other ops are unaffected.

## Test plan
- Reset: clear=0 mid-run with Z nonzero → C_out_HI = C_out_LO = 0 immediately. Release, then add A=5, B=7, Zlowin=1 → C_out_LO = 12 after one edge.
- Arithmetic: sub A=3, B=5 → LO = 32'hFFFFFFFE. add A=32'hFFFFFFFF, B=1 → LO = 0. neg B=1 → LO = 32'hFFFFFFFF.
- Shifts: A=32'h80000001, B=1:
  - shr → 32'h40000000; shra → 32'hC0000000; shl → 32'h00000002.
  - ror → 32'hC0000000; rol → 32'h00000003.
- mul/div:
  - mul A=−3, B=7 → HI = 32'hFFFFFFFF, LO = 32'hFFFFFFEB.
  - div A=−7, B=2 → LO = −3, HI = −1.
  - div by 0 → LO = 32'hFFFFFFFF, HI = A.
  - With ALU_DIV_EN undefined → HI = LO = 0.
- Branch/IncPC:
  - brx A=100, B=20, branch_flag=1 → LO = 120; branch_flag=0 → LO = 100.
  - IncPC=1 with opcode=mul, B=40 → LO = 41, HI = 0.
- Enables: Zhighin=1, Zlowin=0 on mul → only C_out_HI updates; C_out_LO keeps its previous value.

Source files
------------

// File: rtl/src_alu32.sv
// Mini-SRC 32-bit ALU with Zhigh/Zlow result registers; results land in Z one clock after the operands, with no handshake.
// Define ALU_DIV_EN to build the signed divider for opcode 10000; without it that opcode gives HI = LO = 0.
module src_alu32 (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  opcode,
    input  logic        IncPC,
    input  logic        branch_flag,
    input  logic        Zhighin,
    input  logic        Zlowin,
    output logic [31:0] C_out_HI,
    output logic [31:0] C_out_LO
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BRX  = 5'b10011;

    logic [5:0]         w_sh;
    logic signed [63:0] w_prod;
    logic [31:0]        w_hi;
    logic [31:0]        w_lo;
    logic [31:0]        r_zhigh;
    logic [31:0]        r_zlow;

    // Zero-extended to 6 bits so (32 - w_sh) is exact; a shift by 32 yields 0, making rotate-by-0 return A.
    assign w_sh   = {1'b0, B[4:0]};
    assign w_prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

`ifdef ALU_DIV_EN
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // Divide-by-zero and the single overflowing case are pinned explicitly rather than left to operator semantics.
    always_comb begin
        w_quo = 32'hFFFF_FFFF;
        w_rem = A;
        if (B == 32'd0) begin
            w_quo = 32'hFFFF_FFFF;
            w_rem = A;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
            w_quo = 32'h8000_0000;
            w_rem = 32'd0;
        end else begin
            w_quo = $signed(A) / $signed(B);
            w_rem = $signed(A) % $signed(B);
        end
    end
`endif

    always_comb begin
        w_hi = 32'd0;
        w_lo = 32'd0;
        if (IncPC) begin
            w_lo = B + 32'd1;
        end else begin
            case (opcode)
                OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: w_lo = A + B;
                OP_SUB:           w_lo = A - B;
                OP_AND, OP_ANDI:  w_lo = A & B;
                OP_OR, OP_ORI:    w_lo = A | B;
                OP_SHR:           w_lo = A >> w_sh;
                OP_SHRA:          w_lo = $signed(A) >>> w_sh;
                OP_SHL:           w_lo = A << w_sh;
                OP_ROR:           w_lo = (A >> w_sh) | (A << (6'd32 - w_sh));
                OP_ROL:           w_lo = (A << w_sh) | (A >> (6'd32 - w_sh));
                OP_MUL: begin
                    w_hi = w_prod[63:32];
                    w_lo = w_prod[31:0];
                end
                OP_DIV: begin
`ifdef ALU_DIV_EN
                    w_hi = w_rem;
                    w_lo = w_quo;
`else
                    w_hi = 32'd0;
                    w_lo = 32'd0;
`endif
                end
                OP_NEG:           w_lo = 32'd0 - B;
                OP_NOT:           w_lo = ~B;
                OP_BRX:           w_lo = branch_flag ? (A + B) : A;
                default:          w_lo = B;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_zhigh <= 32'd0;
            r_zlow  <= 32'd0;
        end else begin
            if (Zhighin) r_zhigh <= w_hi;
            if (Zlowin)  r_zlow  <= w_lo;
        end
    end

    assign C_out_HI = r_zhigh;
    assign C_out_LO = r_zlow;

endmodule

// File: tb/tb_src_alu32.sv
// Directed-vector bench for src_alu32: expected Z contents are queued at issue and checked by a separate monitor.
module tb_src_alu32;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] A, B;
    logic [4:0]  opcode;
    logic        IncPC, branch_flag, Zhighin, Zlowin;
    logic [31:0] C_out_HI, C_out_LO;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];
    logic        mon_vld = 1'b0;

    src_alu32 dut (
        .clock      (clock),
        .clear      (clear),
        .A          (A),
        .B          (B),
        .opcode     (opcode),
        .IncPC      (IncPC),
        .branch_flag(branch_flag),
        .Zhighin    (Zhighin),
        .Zlowin     (Zlowin),
        .C_out_HI   (C_out_HI),
        .C_out_LO   (C_out_LO)
    );

    always #5 clock = ~clock;

    // Monitor: one expected Z state per issued vector, compared away from the rising edge.
    always @(negedge clock) begin
        if (mon_vld) begin
            mon_vld = 1'b0;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: output presented with no expected entry");
            end else begin
                logic [63:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({C_out_HI, C_out_LO} !== e) begin
                    n_bad++;
                    $display("FAIL %s: got HI=%h LO=%h, expected HI=%h LO=%h",
                             nm, C_out_HI, C_out_LO, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic apply(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic inc, input logic bf, input logic zh, input logic zl,
                         input logic [31:0] eh, input logic [31:0] el);
        @(negedge clock);
        #1;
        opcode = op; A = a; B = b; IncPC = inc; branch_flag = bf; Zhighin = zh; Zlowin = zl;
        exp_q.push_back({eh, el});
        name_q.push_back(nm);
        @(posedge clock);
        #1;
        mon_vld = 1'b1;
    endtask

    task automatic check_now(input string nm, input logic [31:0] eh, input logic [31:0] el);
        n_vec++;
        if (C_out_HI !== eh || C_out_LO !== el) begin
            n_bad++;
            $display("FAIL %s: got HI=%h LO=%h, expected HI=%h LO=%h", nm, C_out_HI, C_out_LO, eh, el);
        end
    endtask

    initial begin
        clear = 1'b0; A = '0; B = '0; opcode = '0; IncPC = 1'b0; branch_flag = 1'b0;
        Zhighin = 1'b0; Zlowin = 1'b0;
        #3;
        check_now("reset_initial", 32'd0, 32'd0);
        @(negedge clock);
        clear = 1'b1;

        apply("add_5_7",   5'b00011, 32'd5, 32'd7, 0, 0, 1, 1, 32'd0, 32'd12);
        apply("mul_pre",   5'b01111, 32'hFFFF_FFFD, 32'd7, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Asynchronous clear mid-cycle, then an edge with enables high while still cleared.
        @(negedge clock);
        #2;
        clear = 1'b0;
        #1;
        check_now("clear_async", 32'd0, 32'd0);
        opcode = 5'b00011; A = 32'd5; B = 32'd7; Zhighin = 1'b1; Zlowin = 1'b1;
        @(posedge clock);
        #1;
        check_now("clear_holds", 32'd0, 32'd0);
        @(negedge clock);
        clear = 1'b1;

        apply("add_after_clear", 5'b00011, 32'd5, 32'd7, 0, 0, 0, 1, 32'd0, 32'd12);
        apply("sub_3_5",   5'b00100, 32'd3, 32'd5, 0, 0, 1, 1, 32'd0, 32'hFFFF_FFFE);
        apply("add_wrap",  5'b00011, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 1, 32'd0, 32'd0);
        apply("neg_1",     5'b10001, 32'd9, 32'd1, 0, 0, 1, 1, 32'd0, 32'hFFFF_FFFF);
        apply("not",       5'b10010, 32'd0, 32'h0F0F_0F0F, 0, 0, 1, 1, 32'd0, 32'hF0F0_F0F0);
        apply("shr",       5'b00111, 32'h8000_0001, 32'd1, 0, 0, 1, 1, 32'd0, 32'h4000_0000);
        apply("shra",      5'b01000, 32'h8000_0001, 32'd1, 0, 0, 1, 1, 32'd0, 32'hC000_0000);
        apply("shl",       5'b01001, 32'h8000_0001, 32'd1, 0, 0, 1, 1, 32'd0, 32'h0000_0002);
        apply("ror",       5'b01010, 32'h8000_0001, 32'd1, 0, 0, 1, 1, 32'd0, 32'hC000_0000);
        apply("rol",       5'b01011, 32'h8000_0001, 32'd1, 0, 0, 1, 1, 32'd0, 32'h0000_0003);
        apply("ror_by_0",  5'b01010, 32'h8000_0001, 32'h20, 0, 0, 1, 1, 32'd0, 32'h8000_0001);
        apply("rol_by_0",  5'b01011, 32'h1234_5678, 32'h40, 0, 0, 1, 1, 32'd0, 32'h1234_5678);
        apply("andi",      5'b01101, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 1, 1, 32'd0, 32'h0000_F000);
        apply("ori",       5'b01110, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 1, 1, 32'd0, 32'h0000_FFF0);
        apply("mul_neg3_7", 5'b01111, 32'hFFFF_FFFD, 32'd7, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
`ifdef ALU_DIV_EN
        apply("div_neg7_2", 5'b10000, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        apply("div_by_0",   5'b10000, 32'h0000_1234, 32'd0, 0, 0, 1, 1, 32'h0000_1234, 32'hFFFF_FFFF);
        apply("div_ovf",    5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 1, 32'd0, 32'h8000_0000);
`else
        apply("div_off_a",  5'b10000, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, 1, 32'd0, 32'd0);
        apply("div_off_b",  5'b10000, 32'h0000_1234, 32'd0, 0, 0, 1, 1, 32'd0, 32'd0);
`endif
        apply("brx_taken",  5'b10011, 32'd100, 32'd20, 0, 1, 1, 1, 32'd0, 32'd120);
        apply("brx_not",    5'b10011, 32'd100, 32'd20, 0, 0, 1, 1, 32'd0, 32'd100);
        apply("incpc_mul",  5'b01111, 32'd5, 32'd40, 1, 0, 1, 1, 32'd0, 32'd41);
        apply("en_hi_only", 5'b01111, 32'hFFFF_FFFD, 32'd7, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'd41);
        apply("en_lo_only", 5'b00011, 32'd1, 32'd2, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd3);
        apply("en_none",    5'b00100, 32'd50, 32'd8, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd3);
        apply("passthru",   5'b11111, 32'd77, 32'h0000_ABCD, 0, 0, 1, 1, 32'd0, 32'h0000_ABCD);
        apply("ld_add",     5'b00000, 32'd10, 32'd20, 0, 0, 1, 1, 32'd0, 32'd30);
        apply("addi",       5'b01100, 32'hFFFF_FFF0, 32'd16, 0, 0, 1, 1, 32'd0, 32'd0);

        repeat (3) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
